// File: rtl/isq_age_scheduler_pkg.sv
// isq_age_scheduler_pkg: parameters shared by the issue queue and its age scheduler
package isq_age_scheduler_pkg;
    localparam int DISPATCH_WIDTH = 2;
    localparam int ISQ_DEPTH = 8;
    localparam int ISQ_ENTRY_W = $clog2(ISQ_DEPTH);
    typedef logic [ISQ_ENTRY_W-1:0] isq_idx_t;
endpackage

// File: rtl/isq_age_scheduler_age_matrix.sv
// isq_age_matrix: age matrix (older_q[i][j]=1 means i older than j) and per-bank oldest-ready select
module isq_age_matrix
    import isq_age_scheduler_pkg::*;
#(
    parameter int N = ISQ_DEPTH,
    parameter int EW = $clog2(N)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [DISPATCH_WIDTH-1:0]          alloc_en,
    input  logic [DISPATCH_WIDTH-1:0][EW-1:0]  alloc_idx,
    input  logic [N-1:0]                       valid_q,
    input  logic [N-1:0]                       cand,
    input  logic [DISPATCH_WIDTH-1:0]          issue_stall,
    output logic [DISPATCH_WIDTH-1:0][N-1:0]   grant_oh
);
    logic [N-1:0][N-1:0] older_q, older_d;
    logic [N-1:0] left;
    logic [N:0] sel;
    logic prior;

    function automatic logic [N:0] oldest(input logic [N-1:0] m);
        logic [N-1:0] oh;
        oh = m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (m[j] && older_q[j][i]) oh[i] = 1'b0;
        return {|oh, oh};
    endfunction

    always_comb begin
        left = cand;
        sel = '0;
        grant_oh = '0;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            sel = oldest(left);
            grant_oh[b] = (flush || issue_stall[b] || !sel[N]) ? '0 : sel[N-1:0];
            left = left & ~grant_oh[b];
        end
    end

    // each alloc rewrites both its row and column, so stale bits of freed entries never matter
    always_comb begin
        older_d = older_q;
        prior = 1'b0;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            if (alloc_en[b]) begin
                older_d[alloc_idx[b]] = '0;
                for (int j = 0; j < N; j++) begin
                    prior = valid_q[j];
                    for (int k = 0; k < b; k++)
                        if (alloc_en[k] && int'(alloc_idx[k]) == j) prior = 1'b1;
                    older_d[j][alloc_idx[b]] = prior && (j != int'(alloc_idx[b]));
                end
            end
        end
        if (flush) older_d = '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) older_q <= '0;
        else older_q <= older_d;
endmodule

// File: rtl/isq_age_scheduler.sv
// isq_age_scheduler: issue-queue occupancy, free list and oldest-ready grant per ALU bank.
// Define ISQ_SCHED_PERF_EN to add saturating perf_issued/perf_stall counters.
module isq_age_scheduler
    import isq_age_scheduler_pkg::*;
#(
    parameter int ISSUE_QUEUE_SIZE = ISQ_DEPTH,
    localparam int ENTRY_W = $clog2(ISSUE_QUEUE_SIZE),
    localparam int CNT_W = $clog2(ISSUE_QUEUE_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DISPATCH_WIDTH-1:0]              alloc_en,
    input  logic [DISPATCH_WIDTH-1:0][ENTRY_W-1:0] alloc_idx,
    input  logic                                   flush,
    input  logic [ISSUE_QUEUE_SIZE-1:0]            ready,
    input  logic [DISPATCH_WIDTH-1:0]              issue_stall,
    output logic [DISPATCH_WIDTH-1:0]              grant_valid,
    output logic [DISPATCH_WIDTH-1:0][ENTRY_W-1:0] grant_idx,
    output logic [DISPATCH_WIDTH-1:0][ENTRY_W-1:0] free_idx,
    output logic [CNT_W-1:0]                       free_count,
    output logic                                   full
`ifdef ISQ_SCHED_PERF_EN
    ,
    output logic [31:0]                            perf_issued,
    output logic [31:0]                            perf_stall
`endif
);
    localparam int N = ISSUE_QUEUE_SIZE;

    logic [N-1:0] valid_q, valid_d, cand, gnt_any, avail;
    logic [DISPATCH_WIDTH-1:0][N-1:0] grant_oh;
    logic [CNT_W-1:0] free_count_q, free_count_d;
    logic full_q, full_d;

    assign cand = valid_q & ready;

    isq_age_matrix #(.N(N), .EW(ENTRY_W)) u_age (
        .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en), .alloc_idx(alloc_idx),
        .valid_q(valid_q), .cand(cand), .issue_stall(issue_stall), .grant_oh(grant_oh)
    );

    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            grant_valid[b] = |grant_oh[b];
            grant_idx[b] = '0;
            for (int i = 0; i < N; i++)
                if (grant_oh[b][i]) grant_idx[b] = ENTRY_W'(i);
            gnt_any = gnt_any | grant_oh[b];
        end
        valid_d = valid_q & ~gnt_any;
        for (int b = 0; b < DISPATCH_WIDTH; b++)
            if (alloc_en[b]) valid_d[alloc_idx[b]] = 1'b1;
        if (flush) valid_d = '0;
        free_count_d = CNT_W'(N - $countones(valid_d));
        full_d = int'(free_count_d) < DISPATCH_WIDTH;
    end

    always_comb begin
        avail = ~valid_q;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            free_idx[b] = '0;
            for (int i = N - 1; i >= 0; i--)
                if (avail[i]) free_idx[b] = ENTRY_W'(i);
            avail[free_idx[b]] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid_q <= '0;
            free_count_q <= CNT_W'(N);
            full_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            free_count_q <= free_count_d;
            full_q <= full_d;
        end

    assign free_count = free_count_q;
    assign full = full_q;

`ifdef ISQ_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;
    logic [32:0] issued_sum;

    always_comb begin
        issued_sum = {1'b0, perf_issued_q} + 33'($countones(grant_valid));
        perf_issued_d = issued_sum[32] ? '1 : issued_sum[31:0];
        perf_stall_d = perf_stall_q + 32'(|cand && !(|grant_valid) && !(&perf_stall_q));
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q <= perf_stall_d;
        end

    assign perf_issued = perf_issued_q;
    assign perf_stall = perf_stall_q;
`endif

    for (genvar b = 0; b < DISPATCH_WIDTH; b++) begin : g_chk
        assert property (@(posedge clk) disable iff (rst) !(alloc_en[b] && !flush && valid_q[alloc_idx[b]]));
    end
endmodule

// File: tb/tb_isq_age_scheduler.sv
// tb_isq_age_scheduler: directed vectors, corner sequences and random traffic against an age-ordered list model
module tb_isq_age_scheduler;
    import isq_age_scheduler_pkg::*;

    logic clk = 1'b0, rst = 1'b1, flush;
    logic [1:0] alloc_en, issue_stall, grant_valid;
    logic [1:0][2:0] alloc_idx, grant_idx, free_idx;
    logic [7:0] ready;
    logic [3:0] free_count;
    logic full;
`ifdef ISQ_SCHED_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int tests = 0, fails = 0;
    int age_q[$];

    typedef struct {logic [1:0] gv; int g0, g1, fc, f0, f1; logic full;} obs_t;
    typedef struct {logic [1:0] ae; int i0, i1; logic [7:0] rdy; logic [1:0] st; logic fl; logic [1:0] gv; int g0, g1, fc;} vec_t;

    isq_age_scheduler dut (
        .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush),
        .ready(ready), .issue_stall(issue_stall), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .free_idx(free_idx), .free_count(free_count), .full(full)
`ifdef ISQ_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_q(input int e);
        foreach (age_q[k]) if (age_q[k] == e) return 1'b1;
        return 1'b0;
    endfunction

    // model: age_q lists occupied entries oldest first; grants go to the first ready ones in that order
    task automatic step(input logic [1:0] ae, input int i0, input int i1, input logic [7:0] rdy,
                        input logic [1:0] st, input logic fl, output obs_t d, output obs_t m);
        int c[$];
        int nq[$];
        int fr[$];
        alloc_en = ae;
        alloc_idx[0] = 3'(i0);
        alloc_idx[1] = 3'(i1);
        ready = rdy;
        issue_stall = st;
        flush = fl;
        #4;
        d.gv = grant_valid;
        d.g0 = int'(grant_idx[0]);
        d.g1 = int'(grant_idx[1]);
        d.fc = int'(free_count);
        d.full = full;
        d.f0 = int'(free_idx[0]);
        d.f1 = int'(free_idx[1]);
        m.gv = 2'b00;
        m.g0 = 0;
        m.g1 = 0;
        foreach (age_q[k]) if (rdy[age_q[k]]) c.push_back(age_q[k]);
        if (!fl && !st[0] && c.size() > 0) begin m.gv[0] = 1'b1; m.g0 = c.pop_front(); end
        if (!fl && !st[1] && c.size() > 0) begin m.gv[1] = 1'b1; m.g1 = c.pop_front(); end
        m.fc = 8 - age_q.size();
        m.full = m.fc < 2;
        for (int e = 0; e < 8; e++) if (!in_q(e)) fr.push_back(e);
        m.f0 = fr.size() > 0 ? fr[0] : 0;
        m.f1 = fr.size() > 1 ? fr[1] : 0;
        foreach (age_q[k])
            if (!((m.gv[0] && age_q[k] == m.g0) || (m.gv[1] && age_q[k] == m.g1))) nq.push_back(age_q[k]);
        if (fl) nq.delete();
        else begin
            if (ae[0]) nq.push_back(i0);
            if (ae[1]) nq.push_back(i1);
        end
        age_q = nq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[12];
        obs_t d, m;
        int fr[$];
        int k, i0, i1;
        logic [1:0] ae, st;
        tbl[0]  = '{2'b01, 5, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 8};
        tbl[1]  = '{2'b01, 2, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 7};
        tbl[2]  = '{2'b01, 7, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 6};
        tbl[3]  = '{2'b00, 0, 0, 8'hA4, 2'b00, 1'b0, 2'b11, 5, 2, 5};
        tbl[4]  = '{2'b00, 0, 0, 8'hA4, 2'b00, 1'b0, 2'b01, 7, 0, 7};
        tbl[5]  = '{2'b11, 3, 1, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 8};
        tbl[6]  = '{2'b00, 0, 0, 8'h0A, 2'b00, 1'b0, 2'b11, 3, 1, 6};
        tbl[7]  = '{2'b01, 4, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 8};
        tbl[8]  = '{2'b01, 6, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 7};
        tbl[9]  = '{2'b00, 0, 0, 8'h50, 2'b01, 1'b0, 2'b10, 0, 4, 6};
        tbl[10] = '{2'b00, 0, 0, 8'h50, 2'b00, 1'b0, 2'b01, 6, 0, 7};
        tbl[11] = '{2'b00, 0, 0, 8'h00, 2'b00, 1'b0, 2'b00, 0, 0, 8};
        alloc_en = '0;
        alloc_idx = '0;
        ready = '0;
        issue_stall = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_free_count", free_count, 8);
        chk("reset_full", full, 0);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            step(tbl[v].ae, tbl[v].i0, tbl[v].i1, tbl[v].rdy, tbl[v].st, tbl[v].fl, d, m);
            chk($sformatf("vec%0d_grant_valid", v), d.gv, tbl[v].gv);
            if (tbl[v].gv[0]) chk($sformatf("vec%0d_grant0", v), d.g0, tbl[v].g0);
            if (tbl[v].gv[1]) chk($sformatf("vec%0d_grant1", v), d.g1, tbl[v].g1);
            chk($sformatf("vec%0d_free_count", v), d.fc, tbl[v].fc);
        end

        step(2'b11, 0, 1, 8'h00, 2'b00, 1'b0, d, m);
        ready = 8'hFF;
        #2;
        chk("pre_reset_grant_valid", grant_valid, 2'b11);
        rst = 1'b1;
        #1;
        chk("async_reset_grant_valid", grant_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = '0;
        age_q.delete();
        chk("post_reset_free_count", free_count, 8);
        chk("post_reset_full", full, 0);
        chk("post_reset_free_idx0", free_idx[0], 0);
        chk("post_reset_free_idx1", free_idx[1], 1);

`ifdef ISQ_SCHED_PERF_EN
        step(2'b11, 0, 1, 8'h00, 2'b00, 1'b0, d, m);
        repeat (3) step(2'b00, 0, 0, 8'h03, 2'b11, 1'b0, d, m);
        chk("perf_stall_3", perf_stall, 3);
        chk("perf_issued_0", perf_issued, 0);
        step(2'b00, 0, 0, 8'h03, 2'b00, 1'b0, d, m);
        chk("perf_issued_2", perf_issued, 2);
        chk("perf_stall_hold", perf_stall, 3);
`endif

        step(2'b11, 0, 1, 8'h00, 2'b00, 1'b0, d, m);
        step(2'b11, 2, 3, 8'h00, 2'b00, 1'b0, d, m);
        step(2'b11, 4, 5, 8'h00, 2'b00, 1'b0, d, m);
        step(2'b01, 6, 0, 8'h00, 2'b00, 1'b0, d, m);
        step(2'b11, 7, 0, 8'hFF, 2'b00, 1'b1, d, m);
        chk("flush_grant_valid", d.gv, 0);
        chk("full_free_count", d.fc, 1);
        chk("full_flag", d.full, 1);
        chk("full_free_idx0", d.f0, 7);
        step(2'b00, 0, 0, 8'hFF, 2'b00, 1'b0, d, m);
        chk("after_flush_free_count", d.fc, 8);
        chk("after_flush_full", d.full, 0);
        chk("after_flush_grant_valid", d.gv, 0);

        for (int n = 0; n < 600; n++) begin
            fr.delete();
            for (int e = 0; e < 8; e++) if (!in_q(e)) fr.push_back(e);
            ae = 2'b00;
            i0 = 0;
            i1 = 0;
            if (fr.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, fr.size() - 1);
                i0 = fr[k];
                fr.delete(k);
                ae[0] = 1'b1;
            end
            if (fr.size() > 0 && $urandom_range(0, 1) != 0) begin
                k = $urandom_range(0, fr.size() - 1);
                i1 = fr[k];
                ae[1] = 1'b1;
            end
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            step(ae, i0, i1, 8'($urandom), st, $urandom_range(0, 29) == 0, d, m);
            chk("rand_grant_valid", d.gv, m.gv);
            if (m.gv[0]) chk("rand_grant0", d.g0, m.g0);
            if (m.gv[1]) chk("rand_grant1", d.g1, m.g1);
            chk("rand_free_count", d.fc, m.fc);
            chk("rand_full", d.full, m.full);
            if (m.fc >= 1) chk("rand_free_idx0", d.f0, m.f0);
            if (m.fc >= 2) chk("rand_free_idx1", d.f1, m.f1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
